if_fetch: RTL and testbench

- Instruction-fetch stage for the RISC-V core; it produces the pc/instruction pair that the IF/ID pipeline register captures.
- Fetches each 32-bit instruction as four byte reads from the memory controller's 8-bit port and assembles them little-endian.
- Presents the assembled instruction until ID accepts it, then advances pc by 4.
- Obeys ID stall and branch redirect; a redirect discards any partial fetch.

---
 rtl/if_fetch_pkg.sv | 29 ++
 rtl/if_fetch_byte_assembler.sv | 50 +++++
 rtl/if_fetch.sv | 106 ++++++++++
 tb/tb_if_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;
  localparam int unsigned MemByteW  = 8;
  localparam int unsigned ByteCntW  = 2;
  localparam int unsigned AsmW      = 24;

  typedef logic [InstAddrW-1:0] InstAddrBus;
  typedef logic [InstW-1:0]     InstBus;
  typedef logic [MemByteW-1:0]  MemByteBus;
  typedef logic [ByteCntW-1:0]  byte_cnt_t;

  localparam InstBus ZeroWord = InstBus'(0);
  localparam logic   True     = 1'b1;
  localparam logic   False    = 1'b0;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  // Byte address of lane 'off' of the instruction starting at 'base' (32-bit wrap).
  function automatic InstAddrBus byte_addr(input InstAddrBus base, input byte_cnt_t off);
    return base + InstAddrW'(off);
  endfunction

endpackage

// File: rtl/if_fetch_byte_assembler.sv
// Collects four little-endian bytes into one instruction word.
module if_fetch_byte_assembler
  import if_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear_i,
  input  logic      accept_i,
  input  MemByteBus data_i,
  output byte_cnt_t byte_cnt_o,
  output logic      complete_c_o,
  output InstBus    word_c_o
);

  byte_cnt_t          byte_cnt_q, byte_cnt_d;
  logic [AsmW-1:0]    asm_q, asm_d;

  // Lane write and counter advance; a clear wins over an accepted byte.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear_i) begin
      byte_cnt_d = byte_cnt_t'(0);
      asm_d      = AsmW'(0);
    end else if (accept_i) begin
      byte_cnt_d = byte_cnt_q + byte_cnt_t'(1);
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = data_i;
        2'd1:    asm_d[15:8]  = data_i;
        2'd2:    asm_d[23:16] = data_i;
        default: asm_d        = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= byte_cnt_t'(0);
      asm_q      <= AsmW'(0);
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  assign byte_cnt_o   = byte_cnt_q;
  assign complete_c_o = accept_i && (byte_cnt_q == byte_cnt_t'(3));
  assign word_c_o     = {data_i, asm_q};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: byte-serial fetch, hold until ID accepts, redirect on branch.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter InstAddrBus RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_interception,
  input  logic [31:0]      branch_target,
  input  logic             id_stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ready,
  input  logic [7:0]       mem_data,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_valid
);

  fetch_state_e state_q, state_d;
  InstAddrBus   pc_q, pc_d;
  InstAddrBus   if_pc_q, if_pc_d;
  InstBus       if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;

  logic         accept;
  byte_cnt_t    byte_cnt;
  logic         complete_c;
  InstBus       word_c;

  // mem_ready is only meaningful while a request is outstanding.
  assign accept = (state_q == FETCH) && mem_ready;

  if_fetch_byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (branch_interception),
    .accept_i     (accept),
    .data_i       (mem_data),
    .byte_cnt_o   (byte_cnt),
    .complete_c_o (complete_c),
    .word_c_o     (word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_pc_q    <= InstAddrBus'(0);
      if_inst_q  <= ZeroWord;
      if_valid_q <= False;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_interception) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:   if (complete_c) state_d = HOLD;
        HOLD:    if (!id_stall)  state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // Redirect flushes everything, including a byte-3 completion in the same cycle.
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (branch_interception) begin
      pc_d       = branch_target;
      if_pc_d    = InstAddrBus'(0);
      if_inst_d  = ZeroWord;
      if_valid_d = False;
    end else if (state_q == FETCH) begin
      if (complete_c) begin
        if_pc_d    = pc_q;
        if_inst_d  = word_c;
        if_valid_d = True;
      end
    end else if (!id_stall) begin
      pc_d       = pc_q + InstAddrW'(4);
      if_pc_d    = InstAddrBus'(0);
      if_inst_d  = ZeroWord;
      if_valid_d = False;
    end
  end

  assign mem_req  = (state_q == FETCH);
  assign mem_addr = byte_addr(pc_q, byte_cnt);
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed plus randomized bench for if_fetch against a transaction-level fetch model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        branch_interception;
  logic [31:0] branch_target;
  logic        id_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  logic        m2_req;
  logic [31:0] m2_addr;
  logic [31:0] m2_pc;
  logic [31:0] m2_inst;
  logic        m2_valid;

  int checks = 0;
  int failures = 0;

  // Model state: pc, bytes already fetched, holding flag, expected outputs.
  logic [31:0] m_pc = 32'h0;
  int          m_got = 0;
  bit          m_hold = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_ipc = 32'h0;
  logic [31:0] m_inst = 32'h0;

  // Memory image: addresses 0..3 hold 0x00100513, the rest is a fixed hash.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] sh;
    logic [7:0]  p;
    w = 32'h0010_0513;
    if (a < 32'd4) begin
      sh = w >> {a[1:0], 3'b000};
      return sh[7:0];
    end
    p = a[7:0] * 8'd29;
    return p ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  assign mem_data = mem_byte(mem_addr);

  if_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch_interception (branch_interception),
    .branch_target       (branch_target),
    .id_stall            (id_stall),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ready           (mem_ready),
    .mem_data            (mem_data),
    .if_pc               (if_pc),
    .if_inst             (if_inst),
    .if_valid            (if_valid)
  );

  if_fetch #(.RESET_PC(32'h0000_0080)) dut80 (
    .clk                 (clk),
    .rst                 (rst),
    .branch_interception (branch_interception),
    .branch_target       (branch_target),
    .id_stall            (id_stall),
    .mem_req             (m2_req),
    .mem_addr            (m2_addr),
    .mem_ready           (mem_ready),
    .mem_data            (mem_data),
    .if_pc               (m2_pc),
    .if_inst             (m2_inst),
    .if_valid            (m2_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model with the current inputs, clock once, compare all outputs.
  task automatic step();
    if (rst) begin
      m_pc = 32'h0; m_got = 0; m_hold = 1'b0;
      m_valid = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
    end else if (branch_interception) begin
      m_pc = branch_target; m_got = 0; m_hold = 1'b0;
      m_valid = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
    end else if (!m_hold) begin
      if (mem_ready) begin
        m_got++;
        if (m_got == 4) begin
          m_valid = 1'b1;
          m_ipc   = m_pc;
          m_inst  = mem_word(m_pc);
          m_hold  = 1'b1;
          m_got   = 0;
        end
      end
    end else if (!id_stall) begin
      m_pc = m_pc + 32'd4; m_hold = 1'b0;
      m_valid = 1'b0; m_ipc = 32'h0; m_inst = 32'h0;
    end
    @(posedge clk);
    #1;
    chk("mem_req", {31'b0, mem_req}, {31'b0, !m_hold});
    chk("mem_addr", mem_addr, m_pc + 32'(m_got));
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_pc", if_pc, m_ipc);
    chk("if_inst", if_inst, m_inst);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; branch_interception = 1'b0; branch_target = 32'h0;
    id_stall = 1'b0; mem_ready = 1'b1;

    // Reset state, including the overridden reset pc instance
    step();
    chk("reset_pc80_addr", m2_addr, 32'h0000_0080);
    chk("reset_pc80_req", {31'b0, m2_req}, 32'h1);
    chk("reset_pc80_valid", {31'b0, m2_valid}, 32'h0);
    rst = 1'b0;

    // Test 1: straight fetch of 0x00100513
    chk("t1_addr0", mem_addr, 32'h0);
    steps(4);
    chk("t1_valid", {31'b0, if_valid}, 32'h1);
    chk("t1_inst", if_inst, 32'h0010_0513);
    chk("t1_req", {31'b0, mem_req}, 32'h0);

    // Test 2: ID stall holds outputs, release advances pc
    id_stall = 1'b1;
    steps(3);
    chk("t2_inst_held", if_inst, 32'h0010_0513);
    id_stall = 1'b0;
    step();
    chk("t2_release_addr", mem_addr, 32'h4);
    chk("t2_release_valid", {31'b0, if_valid}, 32'h0);

    // Test 3: redirect with two bytes already accepted
    steps(2);
    branch_interception = 1'b1; branch_target = 32'h100;
    step();
    branch_interception = 1'b0;
    chk("t3_redirect_addr", mem_addr, 32'h100);
    steps(4);
    chk("t3_inst", if_inst, mem_word(32'h100));
    chk("t3_pc", if_pc, 32'h100);

    // Test 4: redirect in HOLD overrides stall
    id_stall = 1'b1; branch_interception = 1'b1; branch_target = 32'h2000;
    step();
    branch_interception = 1'b0; id_stall = 1'b0;
    chk("t4_addr", mem_addr, 32'h2000);
    chk("t4_inst", if_inst, 32'h0);

    // Test 5: gapped mem_ready
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; steps(2);
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; step();
    mem_ready = 1'b1; step();
    chk("t5_not_yet", {31'b0, if_valid}, 32'h0);
    step();
    chk("t5_valid", {31'b0, if_valid}, 32'h1);
    chk("t5_inst", if_inst, mem_word(32'h2000));
    step();

    // Wrap: pc 0xFFFFFFFC advances to 0; unaligned target wraps mem_addr
    branch_interception = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_interception = 1'b0;
    steps(5);
    chk("wrap_pc", mem_addr, 32'h0);
    branch_interception = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    branch_interception = 1'b0;
    steps(2);
    chk("wrap_addr", mem_addr, 32'h0);
    steps(3);

    // Redirect coinciding with byte 3 wins
    steps(3);
    branch_interception = 1'b1; branch_target = 32'h40;
    step();
    branch_interception = 1'b0;
    chk("redir_b3_valid", {31'b0, if_valid}, 32'h0);

    // Test 6: reset at byte_cnt=3
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_addr", mem_addr, 32'h0);
    chk("t6_pc80_addr", m2_addr, 32'h0000_0080);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mem_ready           = ($urandom % 4) != 0;
      id_stall            = ($urandom % 3) == 0;
      branch_interception = ($urandom % 16) == 0;
      branch_target       = $urandom;
      rst                 = ($urandom % 64) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
